// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage : instruction-decode stage between fetch and execute (4290 ISA).
//
// Accepts 32-bit instructions plus PC over a valid/ready handshake, decodes
// them at enqueue time into registered control fields and buffers the
// decoded entries in a DEPTH-entry queue. A RUN/HALTED/TRAP state machine
// stops intake after a HALT (and, optionally, after an illegal encoding)
// until `resume` is pulsed.
//
// Optional feature macro:
//   ID_ILLEGAL_TRAP_EN  defined   : illegal encodings enqueue with
//                                   out_illegal=1 and send the stage to TRAP.
//                       undefined : illegal encodings enqueue as NOPs and
//                                   the state is unaffected.
//
// Parameters:
//   DATA_W  width of the extended immediate (>=16)
//   PC_W    width of the PC travelling with each instruction
//   DEPTH   decoded-queue depth (power of 2, >=2)
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           fetch handshake
//   in_instr, in_pc             instruction word and its address
//   flush                       empty the queue and drop the same-cycle input
//   resume                      leave HALTED/TRAP
//   out_valid/out_ready         execute handshake on the queue head
//   out_pc .. out_illegal       decoded fields of the queue head (0 if empty)
//   halted                      state machine is not in RUN
// -----------------------------------------------------------------------------
module id_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    input  logic              resume,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        out_class,
    output logic [4:0]        out_op,
    output logic              out_set_flags,
    output logic [2:0]        out_dest,
    output logic [2:0]        out_op1,
    output logic [2:0]        out_op2,
    output logic [3:0]        out_cond,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_is_store,
    output logic              out_is_nop,
    output logic              out_is_halt,
    output logic              out_illegal,
    output logic              halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [1:0]        cls;
        logic [4:0]        op;
        logic              set_flags;
        logic [2:0]        dest;
        logic [2:0]        op1;
        logic [2:0]        op2;
        logic [3:0]        cond;
        logic [DATA_W-1:0] imm;
        logic              is_store;
        logic              is_nop;
        logic              is_halt;
        logic              illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_TRAP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_rst_n_q;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    entry_t           r_mem [DEPTH];

    entry_t            w_dec;
    entry_t            w_out;
    logic              w_legal;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [4:0]        w_op;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;

    assign w_op   = in_instr[29:25];
    assign w_zext = DATA_W'(in_instr[15:0]);
    assign w_sext = DATA_W'($signed(in_instr[15:0]));

    // ---------------------------------------------------------------- decode
    always_comb begin
        w_dec     = '0;
        w_legal   = 1'b1;
        w_dec.pc  = in_pc;
        w_dec.cls = in_instr[31:30];
        w_dec.op  = w_op;
        case (in_instr[31:30])
            2'b00: begin
                // op[4]=0 group: MOV/MOVT/CLR/SET/LSL/LSR fill codes 0..5;
                // op[4]=1 group: ALU ops 1..5 with op[3] as set-flags.
                w_legal = (w_op[4:3] == 2'b00 && w_op[2:0] <= 3'd5) ||
                          (w_op[4] && w_op[2:0] >= 3'd1 && w_op[2:0] <= 3'd5);
                w_dec.set_flags = w_op[4] & w_op[3];
                w_dec.dest      = in_instr[24:22];
                w_dec.op1       = in_instr[21:19];
                w_dec.imm       = w_zext;
            end
            2'b01: begin
                w_legal = (w_op[4] && w_op[2:0] >= 3'd1 && w_op[2:0] <= 3'd5) ||
                          (w_op == 5'b10110);
                w_dec.set_flags = w_op[4] & w_op[3];
                w_dec.dest      = in_instr[24:22];
                w_dec.op1       = in_instr[21:19];
                w_dec.op2       = in_instr[18:16];
                w_dec.imm       = w_zext;
            end
            2'b10: begin
                w_dec.dest     = in_instr[24:22];
                w_dec.op1      = in_instr[21:19];
                w_dec.imm      = w_sext;
                w_dec.is_store = w_op[0];
            end
            default: begin
                case (w_op[3:0])
                    4'b0000: w_dec.imm = w_sext;
                    4'b0001: begin
                        w_dec.imm  = w_sext;
                        w_dec.cond = in_instr[24:21];
                    end
                    4'b0010: begin
                        w_dec.imm = w_sext;
                        w_dec.op1 = in_instr[21:19];
                    end
                    default: begin
                        if (w_op[2]) begin
                            w_dec.is_nop = 1'b1;
                        end else if (w_op[3]) begin
                            w_dec.is_halt = 1'b1;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                endcase
            end
        endcase
        // Illegal encodings keep only pc/class/op so execute can still see
        // what arrived, with every operand field cleared.
        if (!w_legal) begin
            w_dec     = '0;
            w_dec.pc  = in_pc;
            w_dec.cls = in_instr[31:30];
            w_dec.op  = w_op;
`ifdef ID_ILLEGAL_TRAP_EN
            w_dec.illegal = 1'b1;
`else
            w_dec.is_nop  = 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------ handshakes
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign in_ready  = r_rst_n_q && !w_full && (r_state == ST_RUN);
    assign out_valid = (r_count != '0);
    // flush wins over both sides: nothing enters, nothing is consumed.
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    // --------------------------------------------------------- state machine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_rst_n_q <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rst_n_q <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_push && w_dec.is_halt) begin
                    w_state_next = ST_HALTED;
                end else if (w_push && w_dec.illegal) begin
                    w_state_next = ST_TRAP;
                end
            end
            ST_HALTED, ST_TRAP: begin
                if (resume) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    assign halted = (r_state != ST_RUN);

    // ----------------------------------------------------------------- queue
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    // Head fields are forced to zero while the queue is empty.
    assign w_out = out_valid ? r_mem[r_rd_ptr] : '0;

    assign out_pc        = w_out.pc;
    assign out_class     = w_out.cls;
    assign out_op        = w_out.op;
    assign out_set_flags = w_out.set_flags;
    assign out_dest      = w_out.dest;
    assign out_op1       = w_out.op1;
    assign out_op2       = w_out.op2;
    assign out_cond      = w_out.cond;
    assign out_imm       = w_out.imm;
    assign out_is_store  = w_out.is_store;
    assign out_is_nop    = w_out.is_nop;
    assign out_is_halt   = w_out.is_halt;
    assign out_illegal   = w_out.illegal;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage : directed self-checking bench for id_stage (DEPTH=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [15:0] in_pc;
    logic        flush;
    logic        resume;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [1:0]  out_class;
    logic [4:0]  out_op;
    logic        out_set_flags;
    logic [2:0]  out_dest;
    logic [2:0]  out_op1;
    logic [2:0]  out_op2;
    logic [3:0]  out_cond;
    logic [31:0] out_imm;
    logic        out_is_store;
    logic        out_is_nop;
    logic        out_is_halt;
    logic        out_illegal;
    logic        halted;

    int n_total = 0;
    int n_pass  = 0;

    id_stage #(.DATA_W(32), .PC_W(16), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .resume(resume),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_class(out_class), .out_op(out_op),
        .out_set_flags(out_set_flags), .out_dest(out_dest),
        .out_op1(out_op1), .out_op2(out_op2), .out_cond(out_cond),
        .out_imm(out_imm), .out_is_store(out_is_store),
        .out_is_nop(out_is_nop), .out_is_halt(out_is_halt),
        .out_illegal(out_illegal), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic [15:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; resume = 1'b0; out_ready = 1'b0;

        // ---------------- reset
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_halted", halted, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        rst_n = 1'b1;
        chk("rel_in_ready_0", in_ready, 0);
        tick();
        chk("rel_in_ready_1", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);

        // ---------------- ADDS decode, one-cycle latency
        send(32'h3288_0005, 16'h0010);
        chk("adds_valid", out_valid, 1);
        chk("adds_class", out_class, 2'b00);
        chk("adds_op", out_op, 5'b11001);
        chk("adds_sflags", out_set_flags, 1);
        chk("adds_dest", out_dest, 2);
        chk("adds_op1", out_op1, 1);
        chk("adds_op2", out_op2, 0);
        chk("adds_imm", out_imm, 32'h0000_0005);
        chk("adds_pc", out_pc, 16'h0010);
        pop();
        chk("adds_popped", out_valid, 0);

        // ---------------- branch sign extension / Bcond
        send(32'hC000_FFFC, 16'h0020);
        chk("b_class", out_class, 2'b11);
        chk("b_imm", out_imm, 32'hFFFF_FFFC);
        chk("b_cond", out_cond, 0);
        pop();
        send(32'hC2A0_0008, 16'h0024);
        chk("bc_cond", out_cond, 4'h5);
        chk("bc_imm", out_imm, 32'h0000_0008);
        pop();

        // ---------------- store: negative offset sign-extended
        send(32'h82D0_8000, 16'h0028);
        chk("st_is_store", out_is_store, 1);
        chk("st_dest", out_dest, 3);
        chk("st_op1", out_op1, 2);
        chk("st_imm", out_imm, 32'hFFFF_8000);
        pop();

        // ---------------- back-pressure with DEPTH=2
        send(32'h0000_8000, 16'h0030);       // MOV, zero-extended imm
        chk("bp_in_ready_1", in_ready, 1);
        send(32'h0000_0001, 16'h0034);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_head_imm", out_imm, 32'h0000_8000);
        in_valid = 1'b1; in_instr = 32'h0000_0002; in_pc = 16'h0038;
        tick();                               // third held by fetch
        chk("bp_held_ready", in_ready, 0);
        chk("bp_stable_pc", out_pc, 16'h0030);
        out_ready = 1'b1;
        tick();
        chk("bp_drain1_pc", out_pc, 16'h0034);
        tick();
        chk("bp_drain2_pc", out_pc, 16'h0038);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("bp_empty", out_valid, 0);

        // ---------------- halt and resume
        send(32'hD000_0000, 16'h0040);
        chk("h_is_halt", out_is_halt, 1);
        chk("h_halted", halted, 1);
        chk("h_in_ready", in_ready, 0);
        in_valid = 1'b1; in_instr = 32'hC800_0000; in_pc = 16'h0044;
        tick();
        pop();
        chk("h_nop_blocked", out_valid, 0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("h_resumed", halted, 0);
        tick();                               // NOP accepted here
        in_valid = 1'b0;
        chk("h_nop_valid", out_valid, 1);
        chk("h_nop_is_nop", out_is_nop, 1);
        chk("h_nop_pc", out_pc, 16'h0044);
        pop();

        // ---------------- illegal encoding
        send(32'h2C00_0000, 16'h0050);
        chk("il_valid", out_valid, 1);
`ifdef ID_ILLEGAL_TRAP_EN
        chk("il_illegal", out_illegal, 1);
        chk("il_halted", halted, 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
`else
        chk("il_is_nop", out_is_nop, 1);
        chk("il_illegal", out_illegal, 0);
        chk("il_halted", halted, 0);
`endif
        pop();

        // ---------------- flush of a full queue
        send(32'h0000_0001, 16'h0060);
        send(32'h0000_0002, 16'h0064);
        chk("fl_full", in_ready, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);

        // ---------------- HALT dropped together with flush
        in_valid = 1'b1; in_instr = 32'hD000_0000; in_pc = 16'h0070;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flh_out_valid", out_valid, 0);
        chk("flh_halted", halted, 0);

        // ---------------- reset mid-operation discards contents
        send(32'h0000_0003, 16'h0080);
        rst_n = 1'b0;
        tick();
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
